// File: rtl/ascii_loader_pkg.sv
// Shared definitions for the ASCII loader and the downstream digit scanner:
// frame depth, pad byte, address/length widths, FSM state encoding and the
// register-file write payload.
package ascii_loader_pkg;

  localparam int unsigned LDR_DEPTH = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned LEN_W     = 5;

  localparam logic [DATA_W-1:0] LDR_PAD_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PAD   = 3'd3,
    ST_GO    = 3'd4,
    ST_WAIT  = 3'd5
  } ldr_state_e;

  // One register-file write: address and byte.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/ascii_loader_if.sv
// Loader bus bundle: byte stream in, register-file write port out, scanner
// go/done handshake and frame status.
//   master : upstream/environment side (drives stream, start, done)
//   slave  : the loader itself
interface ascii_loader_if;
  import ascii_loader_pkg::*;

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] w_addr;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              go;
  logic              done;
  logic              busy;
  logic [LEN_W-1:0]  len;
  logic              overflow;

  modport master (
    output start, in_valid, in_data, in_last, done,
    input  in_ready, w_addr, w_en, w_data, go, busy, len, overflow
  );

  modport slave (
    input  start, in_valid, in_data, in_last, done,
    output in_ready, w_addr, w_en, w_data, go, busy, len, overflow
  );

endinterface

// File: rtl/ascii_loader.sv
// ASCII frame loader: accepts up to DEPTH bytes of a frame into a 16x8
// register file, pads unfilled entries with PAD_CHAR, drops (and flags) any
// excess bytes, then pulses go to the digit scanner and waits for done.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ascii_loader_if.slave (stream in, RF write, go/done, status)
// All bus outputs are registered.
module ascii_loader
  import ascii_loader_pkg::*;
#(
  parameter int unsigned       DEPTH    = LDR_DEPTH,
  parameter logic [DATA_W-1:0] PAD_CHAR = LDR_PAD_CHAR
) (
  input  logic          clk,
  input  logic          rst_n,
  ascii_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(DEPTH);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              go_q, go_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              accept;

  // A byte is taken only while the registered ready is high.
  assign accept = bus.in_valid && in_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    go_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ptr_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          w_en_d   = 1'b1;
          w_addr_d = ptr_q;
          w_data_d = bus.in_data;
          if (len_q < MAX_LEN) len_d = len_q + LEN_W'(1);
          // ptr parks on the last entry instead of wrapping.
          if (ptr_q != LAST_ADDR) ptr_d = ptr_q + ADDR_W'(1);
          if (bus.in_last) begin
            state_d = (ptr_q == LAST_ADDR) ? ST_GO : ST_PAD;
          end else if (ptr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (accept) begin
          ovf_d = 1'b1;
          if (bus.in_last) state_d = ST_GO;
        end
      end

      ST_PAD: begin
        w_en_d   = 1'b1;
        w_addr_d = ptr_q;
        w_data_d = PAD_CHAR;
        if (ptr_q == LAST_ADDR) state_d = ST_GO;
        else                    ptr_d   = ptr_q + ADDR_W'(1);
      end

      // The final write is on the bus during this state, so go lands one
      // cycle later and never overlaps w_en.
      ST_GO: begin
        go_d    = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      go_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      go_q       <= go_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.go       = go_q;
  assign bus.busy     = busy_q;
  assign bus.len      = len_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ascii_loader.sv
// Bench for ascii_loader: directed and random frames, scoreboard of expected
// register-file writes and end-of-frame status checked by a negedge monitor.
module tb_ascii_loader;
  import ascii_loader_pkg::*;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int unsigned len;
    bit          ovf;
  } fin_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ascii_loader_if bus();

  ascii_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rf_wr_t exp_wr[$];
  fin_t   exp_fin[$];
  int     go_seen   = 0;
  int     drv_chk   = 0;
  int     drv_err   = 0;
  int     mon_chk   = 0;
  int     mon_err   = 0;

  // Monitor: every write and every go pulse is matched against the scoreboard.
  always @(negedge clk) begin
    rf_wr_t e;
    fin_t   f;
    if (rst_n) begin
      if (bus.w_en) begin
        mon_chk++;
        if (exp_wr.size() == 0) begin
          mon_err++;
          $display("FAIL wr_unexpected actual addr=%0d data=%h required no write",
                   bus.w_addr, bus.w_data);
        end else begin
          e = exp_wr.pop_front();
          if (bus.w_addr !== e.addr || bus.w_data !== e.data) begin
            mon_err++;
            $display("FAIL wr_data actual addr=%0d data=%h required addr=%0d data=%h",
                     bus.w_addr, bus.w_data, e.addr, e.data);
          end
        end
      end
      if (bus.go) begin
        go_seen++;
        mon_chk++;
        if (exp_fin.size() == 0) begin
          mon_err++;
          $display("FAIL go_unexpected actual go=1 required go=0");
        end else begin
          f = exp_fin.pop_front();
          if (bus.len !== LEN_W'(f.len)) begin
            mon_err++;
            $display("FAIL go_len actual %0d required %0d", bus.len, f.len);
          end
          mon_chk++;
          if (bus.overflow !== f.ovf) begin
            mon_err++;
            $display("FAIL go_ovf actual %0b required %0b", bus.overflow, f.ovf);
          end
          mon_chk++;
          if (exp_wr.size() != 0) begin
            mon_err++;
            $display("FAIL go_early actual pending_writes=%0d required 0", exp_wr.size());
          end
        end
        mon_chk++;
        if (bus.w_en !== 1'b0) begin
          mon_err++;
          $display("FAIL go_with_wen actual w_en=%0b required 0", bus.w_en);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    drv_chk++;
    if (act !== exp) begin
      drv_err++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_w_en"},     32'(bus.w_en),     0);
    chk({tag, "_w_addr"},   32'(bus.w_addr),   0);
    chk({tag, "_w_data"},   32'(bus.w_data),   0);
    chk({tag, "_go"},       32'(bus.go),       0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk({tag, "_len"},      32'(bus.len),      0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 0);
  endtask

  function automatic bytes_t str2q(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bytes_t rand_q(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
    return q;
  endfunction

  // Reference model: first DEPTH bytes land at 0.., the rest of the file is
  // filled with the pad byte, excess bytes only raise overflow.
  task automatic model_frame(input bytes_t d);
    int n = d.size();
    int kept = (n < int'(LDR_DEPTH)) ? n : int'(LDR_DEPTH);
    fin_t f;
    for (int i = 0; i < kept; i++) exp_wr.push_back('{addr: ADDR_W'(i), data: d[i]});
    for (int i = kept; i < int'(LDR_DEPTH); i++)
      exp_wr.push_back('{addr: ADDR_W'(i), data: LDR_PAD_CHAR});
    f.len = kept;
    f.ovf = (n > int'(LDR_DEPTH));
    exp_fin.push_back(f);
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // gap: 0 none, 1 idle cycle before every byte, 2 random idle cycles.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int n = 0;
    int idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    bus.in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (n == 64) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_go();
    int g = go_seen;
    int n = 0;
    while (go_seen == g && n < 200) begin @(posedge clk); #1; n++; end
    if (n == 200) chk("go_timeout", 0, 1);
  endtask

  task automatic finish_frame(input string tag);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      chk({tag, "_wait_busy"}, 32'(bus.busy), 1);
    end
    bus.done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic send_frame(input string tag, input bytes_t d, input int gap);
    model_frame(d);
    start_frame();
    for (int i = 0; i < d.size(); i++) send_byte(d[i], i == d.size() - 1, gap);
    wait_go();
    finish_frame(tag);
  endtask

  initial begin
    bytes_t d;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.done     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; chk("idle_busy", 32'(bus.busy), 0); end

    send_frame("s1", str2q("0123456789ABCDEF"), 0);
    send_frame("s2", str2q("7a3"), 0);
    send_frame("s3", rand_q(18), 0);
    send_frame("s6", str2q("0123456789ABCDEF"), 1);
    send_frame("s6b", str2q("7a3"), 1);

    // Start held and in_valid toggled while waiting for done: no effect.
    d = str2q("42");
    model_frame(d);
    start_frame();
    send_byte(d[0], 1'b0, 0);
    send_byte(d[1], 1'b1, 0);
    wait_go();
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'h39;
      @(posedge clk); #1;
      chk("s5_in_ready", 32'(bus.in_ready), 0);
      chk("s5_busy", 32'(bus.busy), 1);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    finish_frame("s5");

    // Reset after five bytes of a frame.
    d = str2q("98765");
    for (int i = 0; i < 5; i++) exp_wr.push_back('{addr: ADDR_W'(i), data: d[i]});
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(d[i], 1'b0, 0);
    @(posedge clk); #2;
    chk("s4_pending", 32'(exp_wr.size()), 0);
    chk("s4_busy_pre", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("s4");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send_frame("s4_after", str2q("05"), 0);

    for (int k = 0; k < 10; k++)
      send_frame("rnd", rand_q(int'($urandom_range(1, 20))), int'($urandom_range(0, 2)));

    repeat (3) @(posedge clk);
    #1;
    chk("end_wr_queue", 32'(exp_wr.size()), 0);
    chk("end_fin_queue", 32'(exp_fin.size()), 0);
    chk("end_go_count", 32'(go_seen), 17);

    $display("CHECKS %0d ERRORS %0d", drv_chk + mon_chk, drv_err + mon_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
